// File: rtl/vx_commit_arb_pkg.sv
// Shared commit-interface types and unit indices used by the commit collector
// and the dispatch side.
package VX_gpu_pkg;

  localparam int unsigned VX_NUM_UNITS   = 4;
  localparam int unsigned VX_NUM_THREADS = 4;
  localparam int unsigned VX_NW_BITS     = 2;
  localparam int unsigned VX_XLEN        = 32;
  localparam int unsigned VX_RD_BITS     = 5;

  localparam int unsigned COMMIT_ALU = 0;
  localparam int unsigned COMMIT_LSU = 1;
  localparam int unsigned COMMIT_FPU = 2;
  localparam int unsigned COMMIT_SFU = 3;

  typedef struct packed {
    logic [VX_NW_BITS-1:0]             wid;
    logic [VX_NUM_THREADS-1:0]         tmask;
    logic [VX_XLEN-1:0]                pc;
    logic                              wb;
    logic [VX_RD_BITS-1:0]             rd;
    logic [VX_NUM_THREADS*VX_XLEN-1:0] data;
    logic                              eop;
  } commit_data_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_commit_arb_rr_arbiter.sv
// Round-robin arbiter: the request after the last fired grant has highest
// priority; the pointer only moves when the caller reports a fire.
module vx_rr_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                req,
  input  logic                               grant_fire,
  output logic [NUM_REQS-1:0]                grant_oh,
  output logic [idx_width(NUM_REQS)-1:0]     grant_idx,
  output logic                               grant_valid
);

  localparam int unsigned IDX_W = idx_width(NUM_REQS);

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand_idx    = '0;
    for (int unsigned off = 1; off <= NUM_REQS; off++) begin
      cand_idx = IDX_W'((32'(last_q) + off) % NUM_REQS);
      if (!grant_valid && req[cand_idx]) begin
        grant_valid        = 1'b1;
        grant_idx          = cand_idx;
        grant_oh[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (grant_fire) begin
      last_d = grant_idx;
    end
  end

  // Pointer resets to the last index so that request 0 wins first.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= IDX_W'(NUM_REQS - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit collector: round-robin selects one execution-unit commit per cycle,
// registers it onto the register-file writeback port and tracks retirement.
module vx_commit_arb
  import VX_gpu_pkg::*;
#(
  parameter int unsigned NUM_UNITS   = VX_NUM_UNITS,
  parameter int unsigned NUM_THREADS = VX_NUM_THREADS,
  parameter int unsigned NW_BITS     = VX_NW_BITS,
  parameter int unsigned XLEN        = VX_XLEN
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_UNITS-1:0]              commit_valid,
  output logic [NUM_UNITS-1:0]              commit_ready,
  input  logic [NUM_UNITS*NW_BITS-1:0]      commit_wid,
  input  logic [NUM_UNITS*NUM_THREADS-1:0]  commit_tmask,
  input  logic [NUM_UNITS*XLEN-1:0]         commit_pc,
  input  logic [NUM_UNITS-1:0]              commit_wb,
  input  logic [NUM_UNITS*5-1:0]            commit_rd,
  input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] commit_data,
  input  logic [NUM_UNITS-1:0]              commit_eop,
  output logic                              wb_valid,
  output logic [NW_BITS-1:0]                wb_wid,
  output logic [NUM_THREADS-1:0]            wb_tmask,
  output logic [XLEN-1:0]                   wb_pc,
  output logic [4:0]                        wb_rd,
  output logic [NUM_THREADS*XLEN-1:0]       wb_data,
  output logic                              retire_valid,
  output logic [NW_BITS-1:0]                retire_wid,
  output logic [63:0]                       instret
);

  localparam int unsigned IDX_W = idx_width(NUM_UNITS);
  localparam int unsigned DW    = NUM_THREADS * XLEN;

  commit_data_t pkt [NUM_UNITS];
  commit_data_t win;

  logic [NUM_UNITS-1:0] grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 fire;

  logic                   wb_valid_q, wb_valid_d;
  logic [NW_BITS-1:0]     wb_wid_q, wb_wid_d;
  logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
  logic [XLEN-1:0]        wb_pc_q, wb_pc_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [DW-1:0]          wb_data_q, wb_data_d;
  logic                   retire_valid_q, retire_valid_d;
  logic [NW_BITS-1:0]     retire_wid_q, retire_wid_d;
  logic [63:0]            instret_q, instret_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      pkt[i].wid   = commit_wid[i*NW_BITS +: NW_BITS];
      pkt[i].tmask = commit_tmask[i*NUM_THREADS +: NUM_THREADS];
      pkt[i].pc    = commit_pc[i*XLEN +: XLEN];
      pkt[i].wb    = commit_wb[i];
      pkt[i].rd    = commit_rd[i*5 +: 5];
      pkt[i].data  = commit_data[i*DW +: DW];
      pkt[i].eop   = commit_eop[i];
    end
  end

  vx_rr_arbiter #(
    .NUM_REQS (NUM_UNITS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (commit_valid),
    .grant_fire  (fire),
    .grant_oh    (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Ready is masked during reset; the writeback side never stalls, so any
  // grant outside reset is a fire.
  always_comb begin
    commit_ready = reset ? grant_oh : '0;
    fire         = grant_valid && reset;
    win          = pkt[grant_idx];
  end

  always_comb begin
    wb_valid_d     = fire && win.wb;
    retire_valid_d = fire && win.eop;
    wb_wid_d       = wb_wid_q;
    wb_tmask_d     = wb_tmask_q;
    wb_pc_d        = wb_pc_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    retire_wid_d   = retire_wid_q;
    if (fire) begin
      wb_wid_d     = win.wid;
      wb_tmask_d   = win.tmask;
      wb_pc_d      = win.pc;
      wb_rd_d      = win.rd;
      wb_data_d    = win.data;
      retire_wid_d = win.wid;
    end
    instret_d = instret_q + 64'(retire_valid_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_valid_q     <= 1'b0;
      wb_wid_q       <= '0;
      wb_tmask_q     <= '0;
      wb_pc_q        <= '0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      retire_valid_q <= 1'b0;
      retire_wid_q   <= '0;
      instret_q      <= '0;
    end else begin
      wb_valid_q     <= wb_valid_d;
      wb_wid_q       <= wb_wid_d;
      wb_tmask_q     <= wb_tmask_d;
      wb_pc_q        <= wb_pc_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      retire_valid_q <= retire_valid_d;
      retire_wid_q   <= retire_wid_d;
      instret_q      <= instret_d;
    end
  end

  always_comb begin
    wb_valid     = wb_valid_q;
    wb_wid       = wb_wid_q;
    wb_tmask     = wb_tmask_q;
    wb_pc        = wb_pc_q;
    wb_rd        = wb_rd_q;
    wb_data      = wb_data_q;
    retire_valid = retire_valid_q;
    retire_wid   = retire_wid_q;
    instret      = instret_q;
  end

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed plus randomized bench for vx_commit_arb against a behavioural
// round-robin commit model.
module tb_vx_commit_arb;

  localparam int NU = 4;
  localparam int NT = 4;
  localparam int NW = 2;
  localparam int XL = 32;

  logic                clk;
  logic                reset;
  logic [NU-1:0]       commit_valid;
  logic [NU-1:0]       commit_ready;
  logic [NU*NW-1:0]    commit_wid;
  logic [NU*NT-1:0]    commit_tmask;
  logic [NU*XL-1:0]    commit_pc;
  logic [NU-1:0]       commit_wb;
  logic [NU*5-1:0]     commit_rd;
  logic [NU*NT*XL-1:0] commit_data;
  logic [NU-1:0]       commit_eop;
  logic                wb_valid;
  logic [NW-1:0]       wb_wid;
  logic [NT-1:0]       wb_tmask;
  logic [XL-1:0]       wb_pc;
  logic [4:0]          wb_rd;
  logic [NT*XL-1:0]    wb_data;
  logic                retire_valid;
  logic [NW-1:0]       retire_wid;
  logic [63:0]         instret;

  vx_commit_arb #(
    .NUM_UNITS   (NU),
    .NUM_THREADS (NT),
    .NW_BITS     (NW),
    .XLEN        (XL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_wid   (commit_wid),
    .commit_tmask (commit_tmask),
    .commit_pc    (commit_pc),
    .commit_wb    (commit_wb),
    .commit_rd    (commit_rd),
    .commit_data  (commit_data),
    .commit_eop   (commit_eop),
    .wb_valid     (wb_valid),
    .wb_wid       (wb_wid),
    .wb_tmask     (wb_tmask),
    .wb_pc        (wb_pc),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .retire_valid (retire_valid),
    .retire_wid   (retire_wid),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: last granted unit and the registered outputs.
  int          m_last = NU - 1;
  logic        m_wb_valid = 1'b0;
  logic        m_ret_valid = 1'b0;
  logic [NW-1:0]    m_wid = '0;
  logic [NT-1:0]    m_tmask = '0;
  logic [XL-1:0]    m_pc = '0;
  logic [4:0]       m_rd = '0;
  logic [NT*XL-1:0] m_data = '0;
  logic [NW-1:0]    m_ret_wid = '0;
  logic [63:0]      m_instret = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_unit(input int u, input logic [NW-1:0] wid, input logic [NT-1:0] tm,
                          input logic [XL-1:0] pc, input logic wb, input logic [4:0] rd,
                          input logic [NT*XL-1:0] d, input logic eop);
    commit_valid[u]             = 1'b1;
    commit_wid[u*NW +: NW]      = wid;
    commit_tmask[u*NT +: NT]    = tm;
    commit_pc[u*XL +: XL]       = pc;
    commit_wb[u]                = wb;
    commit_rd[u*5 +: 5]         = rd;
    commit_data[u*NT*XL +: NT*XL] = d;
    commit_eop[u]               = eop;
  endtask

  task automatic rand_unit(input int u);
    set_unit(u, NW'($urandom), NT'($urandom), $urandom, 1'($urandom), 5'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
  endtask

  // One clock: check ready combinationally, predict the edge, check outputs.
  task automatic cycle(output logic [NU-1:0] obs_ready);
    int g;
    logic [NU-1:0] exp_ready;
    @(negedge clk);
    #1;
    g = -1;
    exp_ready = '0;
    if (reset) begin
      for (int k = 1; k <= NU; k++) begin
        if (g < 0 && commit_valid[(m_last + k) % NU]) g = (m_last + k) % NU;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    obs_ready = commit_ready;
    chk("commit_ready", commit_ready, exp_ready);
    if (!reset) begin
      m_last = NU - 1;
      m_wb_valid = 0; m_ret_valid = 0; m_wid = '0; m_tmask = '0; m_pc = '0;
      m_rd = '0; m_data = '0; m_ret_wid = '0; m_instret = '0;
    end else if (g >= 0) begin
      m_last      = g;
      m_wb_valid  = commit_wb[g];
      m_ret_valid = commit_eop[g];
      m_wid       = commit_wid[g*NW +: NW];
      m_tmask     = commit_tmask[g*NT +: NT];
      m_pc        = commit_pc[g*XL +: XL];
      m_rd        = commit_rd[g*5 +: 5];
      m_data      = commit_data[g*NT*XL +: NT*XL];
      m_ret_wid   = commit_wid[g*NW +: NW];
      if (commit_eop[g]) m_instret = m_instret + 64'd1;
    end else begin
      m_wb_valid  = 0;
      m_ret_valid = 0;
    end
    @(posedge clk);
    #1;
    chk("wb_valid", wb_valid, m_wb_valid);
    chk("retire_valid", retire_valid, m_ret_valid);
    chk("wb_wid", wb_wid, m_wid);
    chk("wb_tmask", wb_tmask, m_tmask);
    chk("wb_pc", wb_pc, m_pc);
    chk("wb_rd", wb_rd, m_rd);
    chk("wb_data", wb_data, m_data);
    chk("retire_wid", retire_wid, m_ret_wid);
    chk("instret", instret, m_instret);
  endtask

  logic [NU-1:0] rdy;
  int   ready_cnt [NU];
  int   wb_pulses, ret_pulses, wait_cnt [NU];
  logic [63:0] base;
  bit   found;

  initial begin
    reset = 1'b0;
    commit_valid = '0; commit_wid = '0; commit_tmask = '0; commit_pc = '0;
    commit_wb = '0; commit_rd = '0; commit_data = '0; commit_eop = '0;

    // Reset held with every unit requesting.
    for (int u = 0; u < NU; u++) set_unit(u, NW'(u), 4'hF, 32'h100 * u, 1'b1, 5'(u + 1), 128'(u), 1'b1);
    for (int c = 0; c < 3; c++) begin
      cycle(rdy);
      chk("reset_ready", rdy, 4'b0000);
      chk("reset_wb_valid", wb_valid, 1'b0);
      chk("reset_instret", instret, 64'd0);
    end

    // All units valid for 8 cycles: strict rotation starting at unit 0.
    reset = 1'b1;
    for (int u = 0; u < NU; u++) ready_cnt[u] = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(rdy);
      chk("rr_order", rdy, 4'b0001 << (c % NU));
      for (int u = 0; u < NU; u++) if (rdy[u]) ready_cnt[u]++;
    end
    for (int u = 0; u < NU; u++) chk("ready_count", ready_cnt[u], 2);
    chk("instret_after_8", instret, 64'd8);
    commit_valid = '0;

    // Single ALU commit.
    set_unit(0, 2'd1, 4'b1011, 32'h0000_1000, 1'b1, 5'd5,
             128'h00000004_00000003_00000002_00000001, 1'b1);
    cycle(rdy);
    commit_valid = '0;
    chk("alu_wb_valid", wb_valid, 1'b1);
    chk("alu_wid", wb_wid, 2'd1);
    chk("alu_tmask", wb_tmask, 4'b1011);
    chk("alu_rd", wb_rd, 5'd5);
    chk("alu_data", wb_data, 128'h00000004_00000003_00000002_00000001);
    chk("alu_retire", retire_valid, 1'b1);
    chk("alu_retire_wid", retire_wid, 2'd1);
    chk("alu_instret", instret, 64'd9);

    // LSU multi-packet instruction: eop only on the third packet.
    base = instret;
    wb_pulses = 0; ret_pulses = 0;
    for (int p = 0; p < 3; p++) begin
      set_unit(1, 2'd2, 4'b0000, 32'h2000, 1'b1, 5'd7, 128'(p + 10), p == 2);
      cycle(rdy);
      if (wb_valid) wb_pulses++;
      if (retire_valid) ret_pulses++;
      if (p < 2) chk("lsu_no_retire", retire_valid, 1'b0);
    end
    commit_valid = '0;
    chk("lsu_wb_pulses", wb_pulses, 3);
    chk("lsu_retire_pulses", ret_pulses, 1);
    chk("lsu_instret", instret, base + 64'd1);
    chk("lsu_zero_tmask", wb_tmask, 4'b0000);

    // SFU without writeback still retires; data fields hold on idle cycle.
    set_unit(3, 2'd3, 4'hF, 32'h3000, 1'b0, 5'd9, 128'hABCD, 1'b1);
    cycle(rdy);
    commit_valid = '0;
    chk("sfu_wb_valid", wb_valid, 1'b0);
    chk("sfu_retire", retire_valid, 1'b1);
    chk("sfu_retire_wid", retire_wid, 2'd3);
    cycle(rdy);
    chk("idle_hold_data", wb_data, 128'hABCD);

    // instret wrap at 2^64.
    @(negedge clk);
    force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.instret_d;
    m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("instret_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    set_unit(2, 2'd0, 4'h1, 32'h4000, 1'b1, 5'd1, 128'h1, 1'b1);
    cycle(rdy);
    commit_valid = '0;
    chk("instret_wrap", instret, 64'd0);

    // Reset asserted in the cycle unit 2 would be granted.
    for (int u = 0; u < NU; u++) set_unit(u, NW'(u), 4'hF, 32'h500 + u, 1'b1, 5'(u), 128'(u + 100), 1'b1);
    found = 0;
    for (int c = 0; c < 2 * NU && !found; c++) begin
      cycle(rdy);
      if (rdy[1]) found = 1;
    end
    chk("reach_unit1_grant", found, 1'b1);
    reset = 1'b0;
    cycle(rdy);
    chk("midreset_ready", rdy, 4'b0000);
    chk("midreset_wb_valid", wb_valid, 1'b0);
    chk("midreset_retire", retire_valid, 1'b0);
    chk("midreset_instret", instret, 64'd0);
    reset = 1'b1;
    cycle(rdy);
    chk("post_reset_grant", rdy, 4'b0001);

    // Randomized traffic: a request stays up until it fires.
    commit_valid = '0;
    for (int u = 0; u < NU; u++) wait_cnt[u] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < NU; u++) if (!commit_valid[u] && $urandom_range(0, 2) != 0) rand_unit(u);
      cycle(rdy);
      for (int u = 0; u < NU; u++) begin
        if (rdy[u]) begin
          commit_valid[u] = 1'b0;
          wait_cnt[u] = 0;
        end else if (commit_valid[u]) begin
          wait_cnt[u]++;
          if (wait_cnt[u] >= NU) chk("starvation", wait_cnt[u], NU - 1);
        end
      end
    end
    commit_valid = '0;
    cycle(rdy);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vx_commit_arb.md
Name: vx_commit_arb

Overview:
- Collector at the far end of the commit interface that the execution units drive.
- One instance per issue slot.
- Accepts commit streams from the ALU, LSU, FPU and SFU units as a valid/ready slave and selects one per cycle with a round-robin policy.
- Registers the winner into a single writeback port for the register file and emits retire information (instruction-retired pulse, 64-bit retired counter) for the CSR/perf path.

Parameters:
- NUM_UNITS, 4, number of commit sources (index 0=ALU, 1=LSU, 2=FPU, 3=SFU).
- NUM_THREADS, 4, threads per warp.
- NW_BITS, 2, warp-id width.
- XLEN, 32, data/PC width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- commit_valid  in  NUM_UNITS  per-unit commit valid.
- commit_ready  out  NUM_UNITS  per-unit accept, one-hot or zero.
- commit_wid  in  NUM_UNITS*NW_BITS  warp id.
- commit_tmask  in  NUM_UNITS*NUM_THREADS  thread mask.
- commit_pc  in  NUM_UNITS*XLEN  instruction PC.
- commit_wb  in  NUM_UNITS  register writeback requested.
- commit_rd  in  NUM_UNITS*5  destination register.
- commit_data  in  NUM_UNITS*NUM_THREADS*XLEN  per-thread result.
- commit_eop  in  NUM_UNITS  last packet of the instruction.
- wb_valid  out  1  register-file write strobe.
- wb_wid  out  NW_BITS  warp id.
- wb_tmask  out  NUM_THREADS  thread mask.
- wb_pc  out  XLEN  PC.
- wb_rd  out  5  destination register.
- wb_data  out  NUM_THREADS*XLEN  write data.
- retire_valid  out  1  one instruction retired this cycle.
- retire_wid  out  NW_BITS  warp of the retired instruction.
- instret  out  64  total retired instructions.

Behaviour:
- Reset (reset==0 at a clk edge):
  - wb_valid, retire_valid, wb_* fields, retire_wid and instret all clear to 0.
  - Round-robin pointer is set so unit 0 has highest priority.
  - commit_ready is 0 during reset.
- Arbitration (combinational):
  - Priority order is (last_grant+1) mod NUM_UNITS upward, wrapping.
  - grant = first valid unit in that order.
  - commit_ready = onehot(grant) when any valid, else 0. A unit's ready never depends on its own data fields.
- Fire: fire_i = commit_valid[i] && commit_ready[i]. At most one fire per cycle.
- Pointer: last_grant updates to the granted index only on a fire cycle and holds otherwise.
- Output register (1-cycle latency from the fire edge):
  - wb_valid = fire && wb of the winner.
  - retire_valid = fire && eop of the winner.
  - wb_wid/tmask/pc/rd/data and retire_wid load from the winner on fire.
  - Data fields hold their previous values when not firing. Only the valids drop to 0.
- No backpressure from writeback: the register file always accepts, so throughput is 1 commit/cycle.
- A commit with wb=0 still fires and still counts toward retire on eop, but produces wb_valid=0.
- A multi-packet instruction (eop=0 packets) writes back each packet but retires only on its eop packet.
- instret increments by 1 in the cycle retire_valid is registered. It wraps modulo 2^64 with no saturation.
- A source that holds valid with unchanged data while not granted must be granted within NUM_UNITS cycles (starvation freedom).
- Reset asserted mid-stream: any in-flight registered output is dropped and instret clears. There is no partial-commit recovery; upstream units are reset by the same signal.
- A unit whose tmask is all zero is still legal and is passed through unchanged.

Decomposition:
- Shared package VX_gpu_pkg gets typedef commit_data_t {wid, tmask, pc, wb, rd, data, eop}, plus constants for the unit indices (COMMIT_ALU=0, COMMIT_LSU=1, COMMIT_FPU=2, COMMIT_SFU=3).
- One natural sub-module: vx_rr_arbiter (NUM_REQS parameter, req vector in, onehot grant and grant index out, internal pointer advanced by a grant_fire input). It is reused by the dispatch side.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all commit_valid=1 -> commit_ready=0, wb_valid=0, instret=0; release -> first grant is unit 0.
- Single source: ALU commits wid=1, tmask=4'b1011, rd=5, data={1,2,3,4}, wb=1, eop=1 -> next cycle wb_valid=1 with those fields, retire_valid=1, retire_wid=1, instret=1.
- All four units valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3, each unit's ready high exactly 2 cycles, instret=8.
- LSU packets eop=0,0,1 with wb=1 -> three wb_valid pulses, one retire_valid on the third, instret +1.
- SFU commit with wb=0, eop=1 -> wb_valid=0, retire_valid=1.
- Preload instret=2^64-1 via force, then one retire -> instret=0. Assert reset mid-stream while unit 2 is granted -> outputs 0 next cycle, and after release the priority restarts at unit 0.
